// File: rtl/whackmole_game.sv
// Whack-a-mole game core: IDLE/PLAY/OVER round control, LFSR mole spawning,
// per-mole lifetimes, edge-detected hits, saturating score and miss counters.
module whackmole_game #(
    parameter int          N_HOLES      = 18,
    parameter int          MAX_MOLES    = 4,
    parameter int          SPAWN_PERIOD = 25_000_000,
    parameter int          MOLE_LIFE    = 50_000_000,
    parameter int          MAX_MISSES   = 5,
    parameter int          WRONG_PEN    = 0,
    parameter int          SCORE_W      = 16,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [N_HOLES-1:0]                  SW,
    output logic [N_HOLES-1:0]                  LEDR,
    output logic [N_HOLES-1:0]                  hit_reg,
    output logic [SCORE_W-1:0]                  score,
    output logic [$clog2(MAX_MISSES+1)-1:0]     misses,
    output logic                                playing,
    output logic                                game_over
);

    localparam int MW = $clog2(MAX_MISSES + 1);
    localparam int CW = $clog2(SPAWN_PERIOD);
    localparam int LW = $clog2(MOLE_LIFE);
    localparam int IW = $clog2(N_HOLES);

    localparam logic [CW-1:0] SPAWN_LAST = CW'(SPAWN_PERIOD - 1);
    localparam logic [LW-1:0] LIFE_INIT  = LW'(MOLE_LIFE - 1);
    localparam logic [MW-1:0] MISS_MAX   = MW'(MAX_MISSES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_OVER
    } state_t;

    state_t                         state_q, state_d;
    logic [N_HOLES-1:0]             sw_q, sw_d;
    logic [N_HOLES-1:0]             ledr_q, ledr_d;
    logic [N_HOLES-1:0]             hit_q, hit_d;
    logic [SCORE_W-1:0]             score_q, score_d;
    logic [MW-1:0]                  misses_q, misses_d;
    logic [CW-1:0]                  spawn_q, spawn_d;
    logic [N_HOLES-1:0][LW-1:0]     life_q, life_d;
    logic [15:0]                    lfsr_q, lfsr_d;
    logic                           playing_q, playing_d;
    logic                           over_q, over_d;

    logic [N_HOLES-1:0]             sw_edge;
    logic [N_HOLES-1:0]             hits;
    logic [N_HOLES-1:0]             wrongs;
    logic [N_HOLES-1:0]             timeouts;
    logic [15:0]                    lfsr_nx;
    logic [IW-1:0]                  idx;

    function automatic logic [7:0] popcnt(input logic [N_HOLES-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < N_HOLES; i++) n = n + 8'(v[i]);
        return n;
    endfunction

    // Fibonacci taps 16,14,13,11; feedback enters at the LSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s,
                                                     input logic [7:0]         add);
        logic [SCORE_W+7:0] sum;
        sum = (SCORE_W + 8)'(s) + (SCORE_W + 8)'(add);
        if (sum[SCORE_W+7:SCORE_W] != '0) return '1;
        return sum[SCORE_W-1:0];
    endfunction

    function automatic logic [MW-1:0] sat_miss(input logic [MW-1:0] m,
                                               input logic [7:0]    add);
        logic [31:0] sum;
        sum = 32'(m) + 32'(add);
        if (sum >= 32'(MAX_MISSES)) return MISS_MAX;
        return sum[MW-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        sw_d     = SW;
        ledr_d   = ledr_q;
        hit_d    = '0;
        score_d  = score_q;
        misses_d = misses_q;
        spawn_d  = spawn_q;
        life_d   = life_q;
        lfsr_d   = lfsr_q;
        sw_edge  = SW ^ sw_q;
        hits     = '0;
        wrongs   = '0;
        timeouts = '0;
        lfsr_nx  = lfsr_step(lfsr_q);
        idx      = lfsr_nx[IW-1:0];

        case (state_q)
            S_PLAY: begin
                hits = sw_edge & ledr_q;
                if (WRONG_PEN != 0) wrongs = sw_edge & ~ledr_q;
                // A hit on the last lifetime cycle takes precedence over the timeout.
                for (int i = 0; i < N_HOLES; i++) begin
                    if (ledr_q[i]) begin
                        if (life_q[i] == '0) timeouts[i] = ~hits[i];
                        else                 life_d[i]   = life_q[i] - 1'b1;
                    end
                end
                ledr_d   = ledr_q & ~hits & ~timeouts;
                hit_d    = hits;
                score_d  = sat_score(score_q, popcnt(hits));
                misses_d = sat_miss(misses_q, popcnt(timeouts) + popcnt(wrongs));

                if (spawn_q == SPAWN_LAST) begin
                    spawn_d = '0;
                    lfsr_d  = lfsr_nx;
                    if (32'(idx) < N_HOLES && !ledr_q[idx] && !hits[idx] &&
                        32'(popcnt(ledr_q)) < MAX_MOLES) begin
                        ledr_d[idx] = 1'b1;
                        life_d[idx] = LIFE_INIT;
                    end
                end else begin
                    spawn_d = spawn_q + 1'b1;
                end

                if (misses_d == MISS_MAX) begin
                    state_d = S_OVER;
                    ledr_d  = '0;
                end
            end
            default: begin
                if (start) begin
                    state_d  = S_PLAY;
                    score_d  = '0;
                    misses_d = '0;
                    ledr_d   = '0;
                    spawn_d  = '0;
                    lfsr_d   = LFSR_SEED;
                end
            end
        endcase

        playing_d = (state_d == S_PLAY);
        over_d    = (state_d == S_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sw_q      <= '0;
            ledr_q    <= '0;
            hit_q     <= '0;
            score_q   <= '0;
            misses_q  <= '0;
            spawn_q   <= '0;
            life_q    <= '0;
            lfsr_q    <= LFSR_SEED;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_q      <= sw_d;
            ledr_q    <= ledr_d;
            hit_q     <= hit_d;
            score_q   <= score_d;
            misses_q  <= misses_d;
            spawn_q   <= spawn_d;
            life_q    <= life_d;
            lfsr_q    <= lfsr_d;
            playing_q <= playing_d;
            over_q    <= over_d;
        end
    end

    assign LEDR      = ledr_q;
    assign hit_reg   = hit_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign playing   = playing_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_whackmole_game.sv
// Bench for whackmole_game: directed vector table followed by randomized play
// checked against a cycle-count based reference model.
module tb_whackmole_game;

    localparam int          NH   = 8;
    localparam int          MM   = 2;
    localparam int          SP   = 4;
    localparam int          ML   = 6;
    localparam int          MX   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  sw;
    logic [7:0]  ledr;
    logic [7:0]  hit_reg;
    logic [15:0] score;
    logic [1:0]  misses;
    logic        playing;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    whackmole_game #(
        .N_HOLES(NH), .MAX_MOLES(MM), .SPAWN_PERIOD(SP), .MOLE_LIFE(ML),
        .MAX_MISSES(MX), .WRONG_PEN(1), .SCORE_W(16), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .SW(sw), .LEDR(ledr),
        .hit_reg(hit_reg), .score(score), .misses(misses),
        .playing(playing), .game_over(game_over)
    );

    typedef struct {
        logic        r;
        logic        st;
        logic [7:0]  sw;
        logic [7:0]  led;
        logic [7:0]  hit;
        logic [15:0] sc;
        logic [1:0]  ms;
        logic        pl;
        logic        ov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, st, input logic [7:0] s, led, hit,
                               input logic [15:0] sc, input logic [1:0] ms,
                               input logic pl, ov);
        vec_t x;
        x.r = r; x.st = st; x.sw = s; x.led = led; x.hit = hit;
        x.sc = sc; x.ms = ms; x.pl = pl; x.ov = ov;
        return x;
    endfunction

    task automatic add(input int n, input vec_t x);
        for (int k = 0; k < n; k++) tbl.push_back(x);
    endtask

    task automatic check(input string nm, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got led/hit/score/miss/pl/ov=%h required=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic [7:0] s);
        @(negedge clk);
        rst = r; start = st; sw = s;
        @(posedge clk);
        #1;
    endtask

    // Reference model: moles remember their birth cycle, spawn attempts fall on
    // every SP-th cycle after the round started.
    bit          m_play, m_over;
    logic [7:0]  m_lit, m_hit, m_swq;
    int          m_born[8];
    int          m_score, m_miss, m_t0, m_cyc;
    logic [15:0] m_lfsr;

    task automatic model_step(input logic r, input logic st, input logic [7:0] s);
        logic [7:0] edges, old, hits, wrongs, tmo;
        int idx;
        m_hit = '0;
        if (r) begin
            m_play = 0; m_over = 0; m_lit = '0; m_score = 0; m_miss = 0;
            m_lfsr = SEED; m_t0 = m_cyc;
        end else if (!m_play) begin
            if (st) begin
                m_play = 1; m_over = 0; m_score = 0; m_miss = 0; m_lit = '0;
                m_t0 = m_cyc; m_lfsr = SEED;
            end
        end else begin
            edges  = s ^ m_swq;
            old    = m_lit;
            hits   = edges & old;
            wrongs = edges & ~old;
            tmo    = '0;
            for (int i = 0; i < 8; i++)
                if (old[i] && !hits[i] && (m_cyc - m_born[i] == ML)) tmo[i] = 1'b1;
            m_lit   = old & ~hits & ~tmo;
            m_hit   = hits;
            m_score = m_score + $countones(hits);
            if (m_score > 65535) m_score = 65535;
            m_miss  = m_miss + $countones(tmo) + $countones(wrongs);
            if (m_miss > MX) m_miss = MX;
            if ((m_cyc - m_t0) % SP == 0) begin
                m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                idx = int'(m_lfsr % 16'd8);
                if (!old[idx] && $countones(old) < MM) begin
                    m_lit[idx]  = 1'b1;
                    m_born[idx] = m_cyc;
                end
            end
            if (m_miss == MX) begin
                m_play = 0; m_over = 1; m_lit = '0;
            end
        end
        m_swq = r ? 8'h00 : s;
        m_cyc++;
    endtask

    initial begin
        logic [7:0] s;
        logic       r, st;
        logic [35:0] exp;
        int b;

        rst = 1'b1; start = 1'b0; sw = 8'h00;
        m_cyc = 0; m_swq = '0; m_lit = '0; m_hit = '0; m_play = 0; m_over = 0;
        m_score = 0; m_miss = 0; m_t0 = 0; m_lfsr = SEED;
        for (int i = 0; i < 8; i++) m_born[i] = 0;

        // reset, start, first spawn at idx 3, hit, three timeouts to OVER
        add(1, v(1,0,8'h00, 8'h00,8'h00,0,0,0,0));
        add(1, v(1,0,8'hFF, 8'h00,8'h00,0,0,0,0));
        add(1, v(0,0,8'hFF, 8'h00,8'h00,0,0,0,0));
        add(1, v(0,1,8'hFF, 8'h00,8'h00,0,0,1,0));
        add(3, v(0,0,8'hFF, 8'h00,8'h00,0,0,1,0));
        add(1, v(0,0,8'hFF, 8'h08,8'h00,0,0,1,0));
        add(1, v(0,0,8'hF7, 8'h00,8'h08,1,0,1,0));
        add(2, v(0,0,8'hF7, 8'h00,8'h00,1,0,1,0));
        add(6, v(0,0,8'hF7, 8'h80,8'h00,1,0,1,0));
        add(2, v(0,0,8'hF7, 8'h00,8'h00,1,1,1,0));
        add(4, v(0,0,8'hF7, 8'h40,8'h00,1,1,1,0));
        add(2, v(0,0,8'hF7, 8'h50,8'h00,1,1,1,0));
        add(2, v(0,0,8'hF7, 8'h10,8'h00,1,2,1,0));
        add(2, v(0,0,8'hF7, 8'h12,8'h00,1,2,1,0));
        add(1, v(0,0,8'hF7, 8'h00,8'h00,1,3,0,1));
        // restart from OVER, then reset mid-round
        add(1, v(0,1,8'hF7, 8'h00,8'h00,0,0,1,0));
        add(3, v(0,0,8'hF7, 8'h00,8'h00,0,0,1,0));
        add(1, v(0,0,8'hF7, 8'h08,8'h00,0,0,1,0));
        add(1, v(1,0,8'hF7, 8'h00,8'h00,0,0,0,0));
        add(1, v(0,0,8'hF7, 8'h00,8'h00,0,0,0,0));
        // hit on the final lifetime cycle, then a wrong-hole toggle
        add(1, v(0,1,8'hF7, 8'h00,8'h00,0,0,1,0));
        add(3, v(0,0,8'hF7, 8'h00,8'h00,0,0,1,0));
        add(4, v(0,0,8'hF7, 8'h08,8'h00,0,0,1,0));
        add(2, v(0,0,8'hF7, 8'h88,8'h00,0,0,1,0));
        add(1, v(0,0,8'hFF, 8'h80,8'h08,1,0,1,0));
        add(1, v(0,0,8'hFE, 8'h80,8'h00,1,1,1,0));
        add(1, v(0,0,8'hFE, 8'h80,8'h00,1,1,1,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].st, tbl[i].sw);
            exp = {tbl[i].led, tbl[i].hit, tbl[i].sc, tbl[i].ms, tbl[i].pl, tbl[i].ov};
            check($sformatf("vec%0d", i), {ledr, hit_reg, score, misses, playing, game_over}, exp);
        end

        s = 8'h00;
        drive(1'b1, 1'b0, s);
        model_step(1'b1, 1'b0, s);
        check("rand_rst", {ledr, hit_reg, score, misses, playing, game_over},
              {m_lit, m_hit, 16'(m_score), 2'(m_miss), m_play, m_over});

        for (int n = 0; n < 4000; n++) begin
            r  = ($urandom_range(499) == 0);
            st = ($urandom_range(7) == 0);
            if ($urandom_range(2) == 0) begin
                if (m_lit != 0 && $urandom_range(9) < 7) begin
                    b = $urandom_range(7);
                    for (int k = 0; k < 8 && !m_lit[b]; k++) b = (b + 1) % 8;
                end else begin
                    b = $urandom_range(7);
                end
                s[b] = ~s[b];
            end
            drive(r, st, s);
            model_step(r, st, s);
            check($sformatf("rand%0d", n), {ledr, hit_reg, score, misses, playing, game_over},
                  {m_lit, m_hit, 16'(m_score), 2'(m_miss), m_play, m_over});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
